// File: rtl/payout_scheduler_if.sv
// payout_scheduler_if
// Bundles the payout request/done handshakes and the hopper I/O used by the
// payout scheduler.
//   slave  : the scheduler side (sees requests, drives done/gnt/hopper/status)
//   master : the requester/hopper side (drives requests and the exit sensor)
// Signals:
//   chg_req, chg_amt[2:0] : change payout request and coin count
//   rfd_req, rfd_amt[2:0] : refund payout request and coin count
//   hop_sense             : hopper exit sensor, high while a coin passes
//   chg_done, rfd_done    : 1-cycle completion pulses
//   gnt[1:0]              : one-hot hopper owner ([0]=change, [1]=refund)
//   hop_eject             : hopper solenoid drive
//   busy, jam             : status flags
interface payout_scheduler_if;
  logic       chg_req;
  logic [2:0] chg_amt;
  logic       rfd_req;
  logic [2:0] rfd_amt;
  logic       hop_sense;
  logic       chg_done;
  logic       rfd_done;
  logic [1:0] gnt;
  logic       hop_eject;
  logic       busy;
  logic       jam;

  modport master (
    output chg_req, chg_amt, rfd_req, rfd_amt, hop_sense,
    input  chg_done, rfd_done, gnt, hop_eject, busy, jam
  );

  modport slave (
    input  chg_req, chg_amt, rfd_req, rfd_amt, hop_sense,
    output chg_done, rfd_done, gnt, hop_eject, busy, jam
  );
endinterface

// File: rtl/payout_scheduler.sv
// payout_scheduler
// Arbitrates the coin hopper between the change and refund payout requesters
// (round-robin, refund first after reset), pulses the eject solenoid once per
// coin and credits one exit-sensor edge per eject until the latched amount is
// paid out, then pulses the owner's done output.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : payout_scheduler_if.slave (requests, amounts, hop_sense in;
//           chg_done, rfd_done, gnt, hop_eject, busy, jam out)
// Parameters:
//   EJECT_CYCLES : hop_eject pulse width in cycles (1..15)
//   JAM_TIMEOUT  : cycles in WAIT_SENSE without a coin before a jam (2..255)
// Build option:
//   PAYOUT_JAM_DETECT_EN : when defined, adds the WAIT_SENSE timeout timer and
//   the sticky JAM state; otherwise WAIT_SENSE waits forever and jam is 0.
module payout_scheduler #(
  parameter int EJECT_CYCLES = 4,
  parameter int JAM_TIMEOUT  = 64
) (
  input logic              clk,
  input logic              rst,
  payout_scheduler_if.slave bus
);

  if (EJECT_CYCLES < 1 || EJECT_CYCLES > 15 || JAM_TIMEOUT < 2 || JAM_TIMEOUT > 255) begin : g_param_check
    $error("payout_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT      = 3'd1,
    EJECT      = 3'd2,
    WAIT_SENSE = 3'd3,
    DONE       = 3'd4
`ifdef PAYOUT_JAM_DETECT_EN
    ,
    JAM        = 3'd5
`endif
  } state_t;

  localparam logic [3:0] EJECT_LOAD = 4'(EJECT_CYCLES - 1);
`ifdef PAYOUT_JAM_DETECT_EN
  localparam logic [7:0] JAM_LIMIT = 8'(JAM_TIMEOUT - 1);
`endif

  state_t     state_r;
  logic [2:0] rem_r;
  logic [1:0] gnt_r;
  logic       eject_r;
  logic       busy_r;
  logic       chg_done_r;
  logic       rfd_done_r;
  logic       prio_rfd_r;   // 1: refund wins a tie
  logic       armed_r;      // current eject still owed its one credited coin
  logic [3:0] eject_cnt_r;
  logic       sense_r;
`ifdef PAYOUT_JAM_DETECT_EN
  logic [7:0] timer_r;
  logic       jam_r;
`endif

  logic       edge_s;
  logic       credit_s;
  logic [2:0] rem_after_s;
  logic       pick_rfd_s;

  // Registered copy of the exit sensor for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sense_r <= 1'b0;
    end else begin
      sense_r <= bus.hop_sense;
    end
  end

  // Coin credit: one sensor edge per eject, only while ejecting or waiting.
  always_comb begin
    edge_s   = bus.hop_sense & ~sense_r;
    credit_s = 1'b0;
    if ((state_r == EJECT) || (state_r == WAIT_SENSE)) begin
      credit_s = armed_r & edge_s;
    end else begin
      credit_s = 1'b0;
    end
    if (credit_s) begin
      rem_after_s = rem_r - 3'd1;
    end else begin
      rem_after_s = rem_r;
    end
  end

  // Round-robin arbitration between simultaneous requests.
  always_comb begin
    pick_rfd_s = 1'b0;
    if (bus.rfd_req && bus.chg_req) begin
      pick_rfd_s = prio_rfd_r;
    end else if (bus.rfd_req) begin
      pick_rfd_s = 1'b1;
    end else begin
      pick_rfd_s = 1'b0;
    end
  end

  // Payout state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      rem_r       <= 3'd0;
      gnt_r       <= 2'b00;
      eject_r     <= 1'b0;
      busy_r      <= 1'b0;
      chg_done_r  <= 1'b0;
      rfd_done_r  <= 1'b0;
      prio_rfd_r  <= 1'b1;
      armed_r     <= 1'b0;
      eject_cnt_r <= 4'd0;
`ifdef PAYOUT_JAM_DETECT_EN
      timer_r     <= 8'd0;
      jam_r       <= 1'b0;
`endif
    end else begin
      chg_done_r <= 1'b0;
      rfd_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.chg_req || bus.rfd_req) begin
            state_r <= GRANT;
            busy_r  <= 1'b1;
            if (pick_rfd_s) begin
              gnt_r <= 2'b10;
              rem_r <= bus.rfd_amt;
            end else begin
              gnt_r <= 2'b01;
              rem_r <= bus.chg_amt;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        GRANT: begin
          if (rem_r == 3'd0) begin
            state_r    <= DONE;
            chg_done_r <= gnt_r[0];
            rfd_done_r <= gnt_r[1];
          end else begin
            state_r     <= EJECT;
            eject_r     <= 1'b1;
            eject_cnt_r <= EJECT_LOAD;
            armed_r     <= 1'b1;
          end
        end

        EJECT: begin
          // A coin may already clear the sensor while the solenoid is on.
          if (credit_s) begin
            armed_r <= 1'b0;
            rem_r   <= rem_after_s;
          end else begin
            armed_r <= armed_r;
          end
          if (eject_cnt_r == 4'd0) begin
            state_r <= WAIT_SENSE;
            eject_r <= 1'b0;
`ifdef PAYOUT_JAM_DETECT_EN
            timer_r <= 8'd0;
`endif
          end else begin
            eject_cnt_r <= eject_cnt_r - 4'd1;
          end
        end

        WAIT_SENSE: begin
          if (!armed_r || credit_s) begin
            rem_r <= rem_after_s;
            if (rem_after_s != 3'd0) begin
              state_r     <= EJECT;
              eject_r     <= 1'b1;
              eject_cnt_r <= EJECT_LOAD;
              armed_r     <= 1'b1;
            end else begin
              state_r    <= DONE;
              armed_r    <= 1'b0;
              chg_done_r <= gnt_r[0];
              rfd_done_r <= gnt_r[1];
            end
          end
`ifdef PAYOUT_JAM_DETECT_EN
          else if (timer_r == JAM_LIMIT) begin
            state_r <= JAM;
            jam_r   <= 1'b1;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
`else
          else begin
            state_r <= WAIT_SENSE;
          end
`endif
        end

        DONE: begin
          state_r    <= IDLE;
          gnt_r      <= 2'b00;
          busy_r     <= 1'b0;
          prio_rfd_r <= gnt_r[0];  // whoever was not just served goes first
        end

`ifdef PAYOUT_JAM_DETECT_EN
        JAM: begin
          // Sticky until reset; gnt and busy are held as they were.
          state_r <= JAM;
          jam_r   <= 1'b1;
          eject_r <= 1'b0;
        end
`endif

        default: begin
          state_r <= IDLE;
          gnt_r   <= 2'b00;
          eject_r <= 1'b0;
          busy_r  <= 1'b0;
          armed_r <= 1'b0;
          rem_r   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.hop_eject = eject_r;
  assign bus.busy      = busy_r;
  assign bus.chg_done  = chg_done_r;
  assign bus.rfd_done  = rfd_done_r;
`ifdef PAYOUT_JAM_DETECT_EN
  assign bus.jam       = jam_r;
`else
  assign bus.jam       = 1'b0;
`endif

endmodule

// File: tb/tb_payout_scheduler.sv
// tb_payout_scheduler
// Directed and randomized payouts checked cycle by cycle against a
// transaction-level model: each coin costs max(EJECT_CYCLES, sensor offset)+1
// cycles, arbitration is round-robin starting with refund, done follows the
// last coin by one cycle.
module tb_payout_scheduler;
  localparam int E  = 4;
  localparam int JT = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  payout_scheduler_if bus();

  payout_scheduler #(.EJECT_CYCLES(E), .JAM_TIMEOUT(JT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected {gnt, hop_eject, busy, chg_done, rfd_done, jam} per cycle, and
  // the sensor value driven at each cycle, indexed from the request cycle.
  logic [6:0] exp_vec [0:255];
  logic       sense_at[0:255];
  int         t_done;
  bit         rr_rfd_first = 1'b1;

  function automatic logic [6:0] obs();
    return {bus.gnt, bus.hop_eject, bus.busy, bus.chg_done, bus.rfd_done, bus.jam};
  endfunction

  task automatic check(input string tag, input logic [6:0] o, input logic [6:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Build the expected timeline for one payout.
  task automatic build(input bit win_rfd, input int n, input bit dbl, input int fixed_off);
    logic [1:0] g;
    int cur, c, len;
    for (int i = 0; i < 256; i++) begin
      exp_vec[i]  = 7'b0;
      sense_at[i] = 1'b0;
    end
    g = win_rfd ? 2'b10 : 2'b01;
    exp_vec[1] = {g, 1'b0, 1'b1, 3'b000};
    cur = 2;
    for (int k = 0; k < n; k++) begin
      if (dbl && k == 0) c = 0;
      else if (fixed_off >= 0) c = fixed_off;
      else c = int'($urandom_range(E + 3, 1));
      len = ((c > E) ? c : E) + 1;
      for (int j = 0; j < len; j++) begin
        exp_vec[cur + j] = {g, (j < E), 1'b1, 3'b000};
      end
      sense_at[cur + c] = 1'b1;
      if (dbl && k == 0) sense_at[cur + 2] = 1'b1;
      cur += len;
    end
    exp_vec[cur] = {g, 1'b0, 1'b1, ~win_rfd, win_rfd, 1'b0};
    t_done = cur;
  endtask

  // Step cycles from..to comparing against the timeline and driving the sensor.
  task automatic run(input int from, input int to, input string tag,
                     input bit win_rfd, input bit drop_early, input bit scramble);
    for (int t = from; t <= to; t++) begin
      @(negedge clk);
      check(tag, obs(), exp_vec[t]);
      bus.hop_sense = sense_at[t];
      if ((t == 2 && drop_early) || t == t_done) begin
        if (win_rfd) bus.rfd_req = 1'b0;
        else bus.chg_req = 1'b0;
      end
      if (t == 3 && scramble) begin
        if (win_rfd) bus.rfd_amt = 3'($urandom);
        else bus.chg_amt = 3'($urandom);
      end
    end
  endtask

  // Serve every pending request; called at a negedge with the DUT idle.
  task automatic session(input string tag, input bit rq_chg, input bit rq_rfd,
                         input int a_chg, input int a_rfd, input bit dbl_in,
                         input int fixed_off, input bit drop_early,
                         input bit scramble, input bit reraise_in);
    bit pend_c, pend_r, win_rfd, dbl, reraise;
    int n;
    pend_c = rq_chg; pend_r = rq_rfd; dbl = dbl_in; reraise = reraise_in;
    bus.chg_amt = 3'(a_chg);
    bus.rfd_amt = 3'(a_rfd);
    bus.chg_req = rq_chg;
    bus.rfd_req = rq_rfd;
    while (pend_c || pend_r) begin
      win_rfd = pend_r && (!pend_c || rr_rfd_first);
      n = win_rfd ? a_rfd : a_chg;
      build(win_rfd, n, dbl, fixed_off);
      dbl = 1'b0;
      run(1, t_done + 1, tag, win_rfd, drop_early, scramble);
      rr_rfd_first = !win_rfd;
      if (win_rfd) pend_r = 1'b0;
      else pend_c = 1'b0;
      if (reraise) begin
        reraise = 1'b0;
        if (win_rfd) begin
          bus.rfd_amt = 3'(a_rfd); bus.rfd_req = 1'b1; pend_r = 1'b1;
        end else begin
          bus.chg_amt = 3'(a_chg); bus.chg_req = 1'b1; pend_c = 1'b1;
        end
      end
    end
  endtask

  initial begin
    bus.chg_req = 1'b0; bus.chg_amt = 3'd0;
    bus.rfd_req = 1'b0; bus.rfd_amt = 3'd0;
    bus.hop_sense = 1'b0;

    // Reset state, held and after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", obs(), 7'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("reset_release", obs(), 7'b0);

    // Simultaneous pair: refund first; refund re-raised while change waits -> change next.
    session("rr_pair", 1'b1, 1'b1, 1, 1, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    // Three-coin change, sensor 2 cycles after each eject ends.
    session("chg3", 1'b1, 1'b0, 3, 0, 1'b0, E + 1, 1'b0, 1'b0, 1'b0);
    // Zero-coin refund: two-cycle grant, no eject.
    session("rfd0", 1'b0, 1'b1, 0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    // Two sensor edges in one eject credit a single coin.
    session("dbl_edge", 1'b1, 1'b0, 2, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0);

    // Randomized payouts with idle sensor noise between them.
    for (int it = 0; it < 25; it++) begin
      int rq;
      int gap;
      gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        bus.hop_sense = 1'($urandom);
        @(negedge clk);
        check("idle_noise", obs(), 7'b0);
      end
      bus.hop_sense = 1'b0;
      rq = int'($urandom_range(3, 1));
      session("random", rq[0], rq[1], int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
              1'($urandom), -1, 1'($urandom), 1'($urandom), 1'b0);
    end

    // Reset during the second eject of a three-coin refund.
    bus.rfd_amt = 3'd3;
    bus.rfd_req = 1'b1;
    build(1'b1, 3, 1'b0, 1);
    t_done = 1000;
    run(1, 8, "rst_mid_pre", 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check("rst_async", obs(), 7'b0);
    bus.rfd_req = 1'b0;
    bus.hop_sense = 1'b0;
    @(negedge clk);
    check("rst_mid_hold", obs(), 7'b0);
    rst = 1'b1;
    rr_rfd_first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_after", obs(), 7'b0);
    end

    // After reset refund wins a tie again.
    session("rr_after_rst", 1'b1, 1'b1, 0, 1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // Two-coin change with no sensor: jam timeout or indefinite wait.
    bus.chg_amt = 3'd2;
    bus.chg_req = 1'b1;
    build(1'b0, 0, 1'b0, -1);
    for (int t = 1; t < 256; t++) exp_vec[t] = 7'b0;
    exp_vec[1] = {2'b01, 1'b0, 1'b1, 3'b000};
    for (int t = 2; t < 6; t++) exp_vec[t] = {2'b01, 1'b1, 1'b1, 3'b000};
    for (int t = 6; t <= 90; t++) begin
`ifdef PAYOUT_JAM_DETECT_EN
      exp_vec[t] = {2'b01, 1'b0, 1'b1, 2'b00, (t >= 6 + JT)};
`else
      exp_vec[t] = {2'b01, 1'b0, 1'b1, 3'b000};
`endif
    end
    t_done = 1000;
    run(1, 90, "no_sense", 1'b0, 1'b0, 1'b0);
    bus.chg_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("jam_reset", obs(), 7'b0);
    rst = 1'b1;
    @(negedge clk);
    check("jam_after", obs(), 7'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/payout_scheduler.md
PAYOUT_SCHEDULER -- requirements
Module: payout_scheduler

Interface
REQ-001 The block SHALL have parameter EJECT_CYCLES, default 4, the hop_eject pulse width in clk cycles (legal range 1..15).
REQ-002 The block SHALL have parameter JAM_TIMEOUT, default 64, the cycles to wait for hop_sense before declaring a jam (legal range 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port chg_req, input, 1 bit, the change payout request from the vend FSM.
REQ-006 The block SHALL have port chg_amt, input, 3 bits, the change coin count, stable while chg_req is high.
REQ-007 The block SHALL have port rfd_req, input, 1 bit, the cancel/refund payout request.
REQ-008 The block SHALL have port rfd_amt, input, 3 bits, the refund coin count, stable while rfd_req is high.
REQ-009 The block SHALL have port hop_sense, input, 1 bit, the hopper exit sensor, high while a coin passes.
REQ-010 The block SHALL have port chg_done, output, 1 bit, a 1-cycle pulse when a change payout completes.
REQ-011 The block SHALL have port rfd_done, output, 1 bit, a 1-cycle pulse when a refund payout completes.
REQ-012 The block SHALL have port gnt, output, 2 bits, one-hot owner of the hopper ([0]=change, [1]=refund), 00 when idle.
REQ-013 The block SHALL have port hop_eject, output, 1 bit, the hopper solenoid drive.
REQ-014 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-015 The block SHALL have port jam, output, 1 bit, the sticky hopper-jam flag.

Function
REQ-016 The state machine SHALL have states IDLE, GRANT, EJECT, WAIT_SENSE, DONE and JAM.
REQ-017 In IDLE with any request high, the FSM SHALL move to GRANT next cycle, latch the winner's amount into a 3-bit remaining counter, and set gnt.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset refund has priority.
REQ-019 In GRANT, remaining=0 SHALL go to DONE with no eject; otherwise the FSM SHALL go to EJECT.
REQ-020 In EJECT, hop_eject SHALL be high for exactly EJECT_CYCLES cycles, after which the FSM SHALL go to WAIT_SENSE.
REQ-021 Exactly one hop_sense rising edge (edge-detected on a registered copy) SHALL be credited per eject, whether it arrives during EJECT or WAIT_SENSE; further edges before the next eject, and all edges in IDLE, SHALL be ignored.
REQ-022 Each credited coin SHALL decrement remaining; leaving WAIT_SENSE, the FSM SHALL go to EJECT if remaining>0, else to DONE.
REQ-023 DONE SHALL pulse the granted requester's done output for 1 cycle, update the round-robin pointer, clear gnt and return to IDLE.
REQ-024 Deasserting a request mid-payout SHALL NOT abort it; the payout SHALL complete and still issue done.
REQ-025 The latched amount SHALL NOT change when the input amount changes mid-payout.
REQ-026 A request held high after done SHALL be treated as a new request; requesters drop req on done.
REQ-027 Minimum latency for amt=N>0 SHALL be 1+N*(EJECT_CYCLES+1)+1 cycles from IDLE to done.

Reset
REQ-028 rst low SHALL immediately force IDLE, hop_eject=0, gnt=00, chg_done=rfd_done=0, busy=0, jam=0, remaining=0, and pointer=refund-first, regardless of clock.
REQ-029 Reset mid-payout SHALL abandon the payout with no done pulse.

Configuration
REQ-030 With PAYOUT_JAM_DETECT_EN defined, an 8-bit timer SHALL count WAIT_SENSE cycles; reaching JAM_TIMEOUT without a credited coin SHALL enter JAM.
REQ-031 JAM SHALL hold jam=1, busy=1, hop_eject=0 and gnt unchanged, issue no done, and leave only on reset.
REQ-032 Without PAYOUT_JAM_DETECT_EN, the timer and JAM state SHALL be absent, WAIT_SENSE SHALL wait indefinitely, and jam SHALL be tied 0.

Verification
REQ-033 chg_req=1, chg_amt=3, hop_sense pulses 2 cycles after each eject end -> three 4-cycle hop_eject pulses, one chg_done pulse, gnt=01 throughout.
REQ-034 chg_req and rfd_req rise together after reset, amt=1 each -> refund served first, then change; second simultaneous pair -> change first.
REQ-035 rfd_req=1, rfd_amt=0 -> gnt=10 for 2 cycles, rfd_done 2 cycles after request, hop_eject never high.
REQ-036 With the macro defined, chg_amt=2 and no hop_sense -> jam=1 exactly 64 cycles after WAIT_SENSE entry, no chg_done; without the macro -> busy stays 1, jam=0.
REQ-037 rst low during the second eject of a 3-coin refund -> hop_eject=0 asynchronously, no rfd_done, IDLE after release.
REQ-038 Two hop_sense edges within one eject for amt=2 -> only one coin credited, second eject issued.
